// File: rtl/lstm_weight_loader_if.sv
// AXI4-Lite write channels (AW, W, B) between the weight loader and the
// axi4_lite_lstm_layers register block. The read channels stay with the host.
interface lstm_weight_loader_if;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output awaddr, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  awaddr, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/lstm_weight_loader.sv
// Turns a valid/ready word stream into single-beat AXI4-Lite writes to consecutive
// addresses. Optional macro LSTM_LOADER_ABORT_ON_ERROR_EN ends a load on the first error.
module lstm_weight_loader #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [31:0]          base_addr,
   input  logic [CNT_WIDTH-1:0] word_count,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   lstm_weight_loader_if.master axi,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [CNT_WIDTH-1:0] err_count
);

   typedef enum logic [1:0] {IDLE, FETCH, WRITE, RESP} state_t;

   state_t               state_q, state_d;
   logic [31:0]          base_q, base_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [CNT_WIDTH-1:0] idx_q, idx_d;
   logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
   logic [31:0]          awaddr_q, awaddr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic                 in_ready_q, in_ready_d;
   logic                 awvalid_q, awvalid_d;
   logic                 wvalid_q, wvalid_d;
   logic                 bready_q, bready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;
   logic                 resp_bad;
   logic                 resp_last;

   // NOTE: every variable gets its default before the case; a path that leaves one
   // unassigned would infer a latch.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      count_d     = count_q;
      idx_d       = idx_q;
      err_count_d = err_count_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      in_ready_d  = in_ready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
      resp_bad    = 1'b0;
      resp_last   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (word_count != '0) begin
                  base_d      = base_addr & ~32'h3;
                  count_d     = word_count;
                  idx_d       = '0;
                  error_d     = 1'b0;
                  err_count_d = '0;
                  in_ready_d  = 1'b1;
                  busy_d      = 1'b1;
                  state_d     = FETCH;
               end else begin
                  // Empty load: acknowledge without touching the bus.
                  done_d = 1'b1;
               end
            end
         end

         FETCH: begin
            if (in_valid && in_ready_q) begin
               wdata_d    = in_data;
               awaddr_d   = base_q + (32'(idx_q) << 2);
               awvalid_d  = 1'b1;
               wvalid_d   = 1'b1;
               in_ready_d = 1'b0;
               state_d    = WRITE;
            end
         end

         WRITE: begin
            // Address and data channels retire independently, in either order.
            if (axi.awready) awvalid_d = 1'b0;
            if (axi.wready)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = RESP;
            end
         end

         RESP: begin
            if (axi.bvalid) begin
               resp_bad = (axi.bresp != 2'b00);
               if (resp_bad) begin
                  error_d = 1'b1;
                  if (err_count_q != '1) err_count_d = err_count_q + CNT_WIDTH'(1);
               end
               idx_d     = idx_q + CNT_WIDTH'(1);
               resp_last = (idx_d == count_q);
`ifdef LSTM_LOADER_ABORT_ON_ERROR_EN
               resp_last = resp_last | resp_bad;
`endif
               bready_d = 1'b0;
               if (resp_last) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  in_ready_d = 1'b1;
                  state_d    = FETCH;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         base_q      <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         err_count_q <= '0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         in_ready_q  <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         err_count_q <= err_count_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         in_ready_q  <= in_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign err_count   = err_count_q;
   assign axi.awaddr  = awaddr_q;
   assign axi.awprot  = 3'b000;
   assign axi.awvalid = awvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = 4'hF;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;

endmodule

// File: tb/tb_lstm_weight_loader.sv
// Directed bench for lstm_weight_loader: a reactive AXI4-Lite slave and stream source,
// and a transaction-list model checked every cycle. Honours LSTM_LOADER_ABORT_ON_ERROR_EN.
module tb_lstm_weight_loader;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst;
   logic             start;
   logic [31:0]      base_addr;
   logic [CNT_W-1:0] word_count;
   logic [31:0]      in_data;
   logic             in_valid;
   logic             in_ready;
   logic             busy;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] err_count;

   lstm_weight_loader_if axi();

   lstm_weight_loader #(.WIDTH(32), .CNT_WIDTH(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .axi        (axi),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the list of (address, data) writes a load must produce, in order.
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] addr_log[$];
   logic [31:0] data_log[$];
   logic [31:0] stream_q[$];

   // Slave behaviour knobs and observed counters.
   int aw_lat   = 0;
   int w_lat    = 0;
   int err_at   = -1;
   int b_issued = 0;
   int aw_count = 0;
   int b_count  = 0;
   int done_count = 0;

   // Reactive slave plus stream source; drives #1 after each rising edge.
   initial begin : slave_proc
      logic aw_hs, w_hs, b_hs, s_hs, aw_got, w_got;
      int   aw_wait, w_wait;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b0;
      axi.bresp   = 2'b00;
      in_valid    = 1'b0;
      in_data     = '0;
      aw_got = 1'b0; w_got = 1'b0; aw_wait = 0; w_wait = 0;
      forever begin
         @(negedge clk);
         aw_hs = axi.awvalid && axi.awready;
         w_hs  = axi.wvalid && axi.wready;
         b_hs  = axi.bvalid && axi.bready;
         s_hs  = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (!rst) begin
            axi.awready = 1'b0;
            axi.wready  = 1'b0;
            axi.bvalid  = 1'b0;
            aw_got = 1'b0; w_got = 1'b0; aw_wait = 0; w_wait = 0;
         end else begin
            if (s_hs && stream_q.size() > 0) void'(stream_q.pop_front());
            if (aw_hs) begin aw_got = 1'b1; aw_wait = 0; end
            if (w_hs)  begin w_got  = 1'b1; w_wait  = 0; end
            if (b_hs) axi.bvalid = 1'b0;
            if (aw_got && w_got && !axi.bvalid) begin
               b_issued++;
               axi.bresp  = (b_issued == err_at) ? 2'b10 : 2'b00;
               axi.bvalid = 1'b1;
               aw_got = 1'b0; w_got = 1'b0;
            end
            axi.awready = axi.awvalid && !aw_got && (aw_wait >= aw_lat);
            if (axi.awvalid && !axi.awready) aw_wait++;
            axi.wready = axi.wvalid && !w_got && (w_wait >= w_lat);
            if (axi.wvalid && !axi.wready) w_wait++;
         end
         in_valid = (stream_q.size() > 0);
         in_data  = in_valid ? stream_q[0] : 32'h0;
      end
   end

   // Compare process: every cycle, handshakes against the model and protocol rules.
   initial begin : monitor_proc
      logic        p_awv, p_awr, p_wv, p_wr, p_aw_hs, p_w_hs, p_done;
      logic [31:0] p_awaddr, p_wdata;
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_aw_hs = 0; p_w_hs = 0; p_done = 0;
      p_awaddr = '0; p_wdata = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_aw_hs = 0; p_w_hs = 0; p_done = 0;
         end else begin
            if (p_awv && !p_awr && axi.awvalid) check("awaddr_stable", axi.awaddr, p_awaddr);
            if (p_wv && !p_wr && axi.wvalid)    check("wdata_stable", axi.wdata, p_wdata);
            if (p_aw_hs) check("awvalid_drop", axi.awvalid, 1'b0);
            if (p_w_hs)  check("wvalid_drop", axi.wvalid, 1'b0);
            if (in_ready) check("in_ready_excl", axi.awvalid | axi.wvalid | axi.bready, 1'b0);
            if (axi.awvalid && axi.awready) begin
               check("aw_expected", exp_addr_q.size() > 0, 1'b1);
               if (exp_addr_q.size() > 0) check("awaddr", axi.awaddr, exp_addr_q.pop_front());
               check("awprot", axi.awprot, 3'b000);
               addr_log.push_back(axi.awaddr);
               aw_count++;
            end
            if (axi.wvalid && axi.wready) begin
               check("w_expected", exp_data_q.size() > 0, 1'b1);
               if (exp_data_q.size() > 0) check("wdata", axi.wdata, exp_data_q.pop_front());
               check("wstrb", axi.wstrb, 4'hF);
               data_log.push_back(axi.wdata);
            end
            if (axi.bvalid && axi.bready) b_count++;
            if (done) begin
               check("done_pulse", p_done, 1'b0);
               done_count++;
            end
            p_awv = axi.awvalid; p_awr = axi.awready; p_awaddr = axi.awaddr;
            p_wv  = axi.wvalid;  p_wr  = axi.wready;  p_wdata  = axi.wdata;
            p_aw_hs = axi.awvalid && axi.awready;
            p_w_hs  = axi.wvalid && axi.wready;
            p_done  = done;
         end
      end
   end

   task automatic check_reset(input string tag);
      check({tag, "_in_ready"}, in_ready, 1'b0);
      check({tag, "_awvalid"}, axi.awvalid, 1'b0);
      check({tag, "_wvalid"}, axi.wvalid, 1'b0);
      check({tag, "_bready"}, axi.bready, 1'b0);
      check({tag, "_awaddr"}, axi.awaddr, 32'h0);
      check({tag, "_wdata"}, axi.wdata, 32'h0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_error"}, error, 1'b0);
      check({tag, "_err_count"}, err_count, 16'h0);
   endtask

   task automatic pulse_start(input logic [31:0] base, input int cnt);
      @(posedge clk);
      #1;
      start      = 1'b1;
      base_addr  = base;
      word_count = CNT_W'(cnt);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Runs one load: cnt stream words, n_exp writes expected, then checks the end state.
   task automatic run_load(input logic [31:0] base, input int cnt, input logic [31:0] d0,
                           input logic [31:0] step, input int n_exp, input logic exp_err,
                           input int exp_ec, input bit mid_start, output int lat);
      int aw0, b0, dn0;
      bit seen_done, pulsed;
      for (int i = 0; i < cnt; i++) stream_q.push_back(d0 + 32'(i) * step);
      for (int i = 0; i < n_exp; i++) begin
         exp_addr_q.push_back((base & ~32'h3) + 32'(i) * 32'd4);
         exp_data_q.push_back(d0 + 32'(i) * step);
      end
      addr_log.delete();
      data_log.delete();
      aw0 = aw_count; b0 = b_count; dn0 = done_count;
      pulse_start(base, cnt);
      lat = 0; seen_done = 0; pulsed = 0;
      for (int c = 0; c < 400 && !seen_done; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) seen_done = 1;
         else if (busy) lat++;
         if (mid_start && !pulsed && axi.awvalid) begin
            start = 1'b1; word_count = CNT_W'(7); pulsed = 1;
         end
      end
      check("done_seen", seen_done, 1'b1);
      check("done_busy", busy, 1'b0);
      check("load_error", error, exp_err);
      check("load_err_count", err_count, CNT_W'(exp_ec));
      check("write_count", aw_count - aw0, n_exp);
      check("bresp_count", b_count - b0, n_exp);
      check("model_drained", exp_addr_q.size() + exp_data_q.size(), 0);
      repeat (3) @(negedge clk);
      check("done_once", done_count - dn0, 1);
      check("idle_busy", busy, 1'b0);
      check("idle_in_ready", in_ready, 1'b0);
      check("error_held", error, exp_err);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int  lat;
      bit  flag_busy, flag_aw, seen;
      rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
      #1;
      check_reset("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Basic load, zero-wait slave, with literal pins on the model.
      run_load(32'h100, 3, 32'hA, 32'h1, 3, 1'b0, 0, 1'b0, lat);
      check("basic_latency", lat, 9);
      check("basic_a0", addr_log[0], 32'h100);
      check("basic_a1", addr_log[1], 32'h104);
      check("basic_a2", addr_log[2], 32'h108);
      check("basic_d0", data_log[0], 32'hA);
      check("basic_d2", data_log[2], 32'hC);

      // Zero count: done next cycle, no bus activity.
      pulse_start(32'h500, 0);
      @(negedge clk);
      check("zero_done", done, 1'b1);
      check("zero_busy", busy, 1'b0);
      flag_busy = 0; flag_aw = 0;
      repeat (5) begin
         @(negedge clk);
         flag_busy |= busy;
         flag_aw   |= axi.awvalid;
      end
      check("zero_no_busy", flag_busy, 1'b0);
      check("zero_no_aw", flag_aw, 1'b0);

      // Skewed handshakes; misaligned base and address wrap.
      aw_lat = 3; w_lat = 0;
      run_load(32'h2000_0003, 2, 32'h1111_0000, 32'h10, 2, 1'b0, 0, 1'b0, lat);
      check("skew_a1", addr_log[1], 32'h2000_0004);
      aw_lat = 0; w_lat = 3;
      run_load(32'hFFFF_FFF8, 3, 32'h2222_0000, 32'h3, 3, 1'b0, 0, 1'b0, lat);
      check("wrap_a2", addr_log[2], 32'h0000_0000);
      w_lat = 0;

      // SLVERR on the second word of a four-word load.
      err_at = b_issued + 2;
`ifdef LSTM_LOADER_ABORT_ON_ERROR_EN
      run_load(32'h1000, 4, 32'hC0DE_0000, 32'h1, 2, 1'b1, 1, 1'b0, lat);
      check("abort_stream_left", stream_q.size(), 2);
      stream_q.delete();
`else
      run_load(32'h1000, 4, 32'hC0DE_0000, 32'h1, 4, 1'b1, 1, 1'b0, lat);
      check("err_a3", addr_log[3], 32'h100C);
`endif
      err_at = -1;

      // Start while busy is ignored; the accepted start also clears the error state.
      run_load(32'h300, 2, 32'h3333_0000, 32'h1, 2, 1'b0, 0, 1'b1, lat);

      // Reset during WRITE.
      aw_lat = 5;
      stream_q.push_back(32'hDEAD_BEEF);
      exp_addr_q.push_back(32'h40);
      exp_data_q.push_back(32'hDEAD_BEEF);
      pulse_start(32'h40, 1);
      seen = 0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         seen = axi.awvalid;
      end
      check("rst_awvalid_seen", seen, 1'b1);
      rst = 1'b0;
      #1;
      check_reset("mid_reset");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      exp_addr_q.delete(); exp_data_q.delete(); stream_q.delete();
      aw_lat = 0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      run_load(32'h44, 1, 32'h5555_0001, 32'h1, 1, 1'b0, 0, 1'b0, lat);
      check("post_rst_a0", addr_log[0], 32'h44);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/lstm_weight_loader.md
# lstm_weight_loader

AXI4-Lite write-master sequencer that loads weight/bias words into the `axi4_lite_lstm_layers` register space. It takes a valid/ready word stream from the DMA and turns it into one single-beat AXI4-Lite write per word to consecutive addresses from a programmed base. It sits between the stream source and the layer block's write channels. The read channels are not driven and stay with the host.

## Interface
Parameters:
- `WIDTH`, 32: data width. Fixed at 32 to match the AXI4-Lite data bus.
- `CNT_WIDTH`, 16: width of the word count and the error counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a load; sampled in IDLE only.
- `base_addr`  in  32  byte address of the first word; bits [1:0] forced to 0; sampled on start.
- `word_count`  in  CNT_WIDTH  number of words to load; sampled on start.
- `in_data`  in  WIDTH  stream word.
- `in_valid`  in  1  stream word valid.
- `in_ready`  out  1  loader accepts the stream word.
- `awaddr`  out  32  write address.
- `awprot`  out  3  constant 3'b000.
- `awvalid`  out  1  write address valid.
- `awready`  in  1  slave accepts the address.
- `wdata`  out  32  write data.
- `wstrb`  out  4  constant 4'hF.
- `wvalid`  out  1  write data valid.
- `wready`  in  1  slave accepts the data.
- `bresp`  in  2  write response.
- `bvalid`  in  1  response valid.
- `bready`  out  1  loader accepts the response.
- `busy`  out  1  high while a load is in progress.
- `done`  out  1  one-cycle pulse when a load ends.
- `error`  out  1  at least one non-OKAY `bresp` in the current or last load; cleared on the next accepted start.
- `err_count`  out  CNT_WIDTH  number of non-OKAY responses; saturates at all-ones; cleared on start.

## Operation
- The FSM has four states: IDLE, FETCH, WRITE and RESP.
- **IDLE**
  - When `start`=1 and `word_count`≠0: latch `base_addr`, `word_count`; set idx=0; clear `error` and `err_count`; go to FETCH.
  - When `start`=1 and `word_count`=0: pulse `done` and stay in IDLE. No bus activity.
- **FETCH**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: latch `in_data` into `wdata`, set `awaddr` = base + (idx<<2) (mod 2^32), and go to WRITE.
- **WRITE**
  - `awvalid` and `wvalid` both assert on entry.
  - Each deasserts independently after its own handshake; address and data may complete in either order or in the same cycle.
  - When both have completed, go to RESP.
- **RESP**
  - `bready`=1.
  - On `bvalid`: if `bresp`≠2'b00, set `error` and increment `err_count` (saturating).
  - Then set idx=idx+1. If idx equals `word_count`, pulse `done` and go to IDLE; otherwise go to FETCH.
- `start` outside IDLE is ignored. `busy`=1 in FETCH, WRITE and RESP.
- Reset at any point returns to IDLE with all outputs at their reset values. Reset mid-transaction drops `awvalid`/`wvalid` immediately; the slave must be reset together with the loader.

## Timing
- All outputs are registered. Reset values: `in_ready`=0, `awvalid`=0, `wvalid`=0, `bready`=0, `awaddr`=0, `wdata`=0, `busy`=0, `done`=0, `error`=0, `err_count`=0.
- `start` sampled at edge N → `busy`=1 and `in_ready`=1 from N+1.
- Stream handshake at edge M → `awvalid`=`wvalid`=1 from M+1. `in_ready` is 0 from M+1 until the next FETCH.
- With a zero-wait slave (`awready`=`wready`=1, `bvalid` returned the cycle after the write), each word takes 3 cycles: FETCH, WRITE, RESP.
- Final `bvalid` handshake at edge K → `done`=1 and `busy`=0 during cycle K+1 only.
- `awaddr`/`wdata` are stable while `awvalid`/`wvalid` are high.

## Configuration
- Macro: `LSTM_LOADER_ABORT_ON_ERROR_EN`.
- **Defined:** the first non-OKAY `bresp` ends the load. That RESP handshake pulses `done`, sets `error`, sets `err_count`=1 and returns to IDLE. Remaining stream words are left unconsumed.
- **Undefined:** errors are counted and the load always runs to `word_count` words.

## Test plan
- **Basic load:** base=0x100, count=3, stream 0xA,0xB,0xC, zero-wait slave → writes (0x100,0xA), (0x104,0xB), (0x108,0xC); `done` exactly 9 cycles after `busy` rises; `error`=0.
- **Skewed handshakes:** `awready` delayed 3 cycles, `wready` immediate (then the reverse) → each of `awvalid`/`wvalid` drops the cycle after its own handshake; one `bready` handshake per word; data and addresses are correct.
- **Zero count:** start with count=0 → `done` pulse the next cycle, `busy` never rises, no `awvalid`.
- **Error response:** count=4, SLVERR on word 2.
  - Macro undefined → 4 writes, `error`=1, `err_count`=1.
  - Macro defined → 2 writes, `done` after the second response, `in_ready` stays 0 afterward.
- **Start while busy:** second `start` pulse in WRITE → ignored; only the original count is written; exactly one `done`.
- **Reset during WRITE:** assert `rst`=0 with `awvalid` high → all outputs return to reset values immediately; after release, a fresh start with count=1 completes normally.
